ps_rr_scheduler: RTL and testbench

Packet-level round-robin scheduler for the PacketStream interface. It multiplexes NPORTS input streams onto one output, granting one whole packet at a time. It inserts a programmable idle gap after each packet. It sits in front of shared PacketStream sinks (links, FIFOs, framers), so that several producers share one resource fairly and at a bounded rate.

---
 rtl/ps_rr_scheduler.sv | 111 +++++++++++
 tb/tb_ps_rr_scheduler.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps_rr_scheduler.sv
// Packet-level round-robin scheduler for PacketStream inputs.
// Grants whole packets and inserts a programmable idle gap after each.
module ps_rr_scheduler #(
    parameter int DWIDTH = 8,
    parameter int NPORTS = 4,
    parameter int CWIDTH = 8,
    localparam int SWIDTH = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
    input  logic                     reset,
    input  logic                     clk,
    input  logic [CWIDTH-1:0]        gap,
    input  logic [NPORTS*DWIDTH-1:0] i_dat,
    input  logic [NPORTS-1:0]        i_val,
    input  logic [NPORTS-1:0]        i_eop,
    output logic [NPORTS-1:0]        i_rdy,
    output logic [DWIDTH-1:0]        o_dat,
    output logic                     o_val,
    output logic                     o_eop,
    input  logic                     o_rdy,
    output logic [SWIDTH-1:0]        o_sel
);

    typedef enum logic [1:0] {IDLE, PASS, GAP} state_t;

    localparam logic [SWIDTH:0]   NP   = (SWIDTH+1)'(NPORTS);
    localparam logic [SWIDTH-1:0] LAST = SWIDTH'(NPORTS - 1);

    state_t            state;
    logic [SWIDTH-1:0] grant;
    logic [SWIDTH-1:0] ptr;
    logic [CWIDTH-1:0] cnt;
    logic [SWIDTH-1:0] pick;
    logic [SWIDTH-1:0] grant_nxt;
    logic [SWIDTH:0]   sum;
    logic              found;
    logic              eop_xfer;

    // First requester at or after ptr, walking the ports cyclically
    always_comb begin
        pick  = ptr;
        found = 1'b0;
        sum   = '0;
        for (int i = 0; i < NPORTS; i++) begin
            sum = {1'b0, ptr} + (SWIDTH+1)'(i);
            if (sum >= NP)
                sum = sum - NP;
            if (!found && i_val[sum[SWIDTH-1:0]]) begin
                found = 1'b1;
                pick  = sum[SWIDTH-1:0];
            end
        end
    end

    assign grant_nxt = (grant == LAST) ? '0 : grant + SWIDTH'(1);
    assign eop_xfer  = (state == PASS) && i_val[grant]
                       && o_rdy && i_eop[grant];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            grant <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|i_val) begin
                        grant <= pick;
                        state <= PASS;
                    end
                end
                PASS: begin
                    if (eop_xfer) begin
                        ptr <= grant_nxt;
                        if (gap == '0) begin
                            state <= IDLE;
                        end else begin
                            cnt   <= gap;
                            state <= GAP;
                        end
                    end
                end
                GAP: begin
                    cnt <= cnt - CWIDTH'(1);
                    if (cnt == CWIDTH'(1))
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Mux stays on the granted port outside PASS; o_val masks it
    always_comb begin
        o_dat = '0;
        for (int k = 0; k < NPORTS; k++)
            if (grant == SWIDTH'(k))
                o_dat = i_dat[k*DWIDTH +: DWIDTH];
    end

    always_comb begin
        i_rdy = '0;
        if (state == PASS)
            i_rdy[grant] = o_rdy;
    end

    assign o_eop = i_eop[grant];
    assign o_val = (state == PASS) && i_val[grant];
    assign o_sel = grant;

endmodule

// File: tb/tb_ps_rr_scheduler.sv
// Directed bench for ps_rr_scheduler with a packet-level reference model.
// Sources advance on observed handshakes; a negedge process checks every cycle.
module tb_ps_rr_scheduler;

    logic        reset;
    logic        clk;
    logic [7:0]  gap;
    logic [31:0] i_dat;
    logic [3:0]  i_val;
    logic [3:0]  i_eop;
    logic [3:0]  i_rdy;
    logic [7:0]  o_dat;
    logic        o_val;
    logic        o_eop;
    logic        o_rdy;
    logic [1:0]  o_sel;

    ps_rr_scheduler #(.DWIDTH(8), .NPORTS(4), .CWIDTH(8)) dut (
        .reset(reset), .clk(clk), .gap(gap),
        .i_dat(i_dat), .i_val(i_val), .i_eop(i_eop), .i_rdy(i_rdy),
        .o_dat(o_dat), .o_val(o_val), .o_eop(o_eop), .o_rdy(o_rdy),
        .o_sel(o_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Packet-level model: who owns the output, whose turn is next,
    // and how many cycles must pass before arbitration is allowed.
    int   m_busy = 0;
    int   m_grant = 0;
    int   m_ptr = 0;
    int   m_hold = 0;
    int   m_found;
    int   mp;
    logic [3:0] e_rdy;
    int   cyc = 0;

    int         lg_port[$];
    logic [7:0] lg_dat[$];
    logic       lg_eop[$];
    int         lg_cyc[$];

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            chk("rst_o_val", {31'b0, o_val}, 0);
            chk("rst_i_rdy", {28'b0, i_rdy}, 0);
            chk("rst_o_sel", {30'b0, o_sel}, 0);
            m_busy = 0; m_grant = 0; m_ptr = 0; m_hold = 0;
        end else begin
            e_rdy = 4'b0;
            if (m_busy != 0)
                e_rdy[m_grant] = o_rdy;
            chk("o_sel", {30'b0, o_sel}, m_grant);
            chk("i_rdy", {28'b0, i_rdy}, {28'b0, e_rdy});
            chk("o_val", {31'b0, o_val},
                (m_busy != 0 && i_val[m_grant]) ? 1 : 0);
            if (m_busy != 0 && i_val[m_grant]) begin
                chk("o_dat", {24'b0, o_dat},
                    {24'b0, i_dat[m_grant*8 +: 8]});
                chk("o_eop", {31'b0, o_eop}, {31'b0, i_eop[m_grant]});
            end
            if (o_val && o_rdy) begin
                lg_port.push_back(int'(o_sel));
                lg_dat.push_back(o_dat);
                lg_eop.push_back(o_eop);
                lg_cyc.push_back(cyc);
            end
            if (m_busy != 0) begin
                if (i_val[m_grant] && o_rdy && i_eop[m_grant]) begin
                    m_busy = 0;
                    m_ptr  = (m_grant + 1) % 4;
                    m_hold = int'(gap);
                end
            end else if (m_hold > 0) begin
                m_hold--;
            end else if (i_val != 4'b0) begin
                m_found = 0;
                for (int j = 0; j < 4; j++) begin
                    mp = (m_ptr + j) % 4;
                    if (m_found == 0 && i_val[mp]) begin
                        m_found = 1;
                        m_grant = mp;
                        m_busy  = 1;
                    end
                end
            end
        end
    end

    // Per-port packet sources
    bit   en[4];
    bit   stall[4];
    int   len[4];
    int   beat[4];
    int   pkt[4];
    int   maxp[4];
    bit   tog = 0;
    logic [3:0] hs;

    task automatic drive();
        for (int k = 0; k < 4; k++) begin
            i_val[k] = en[k] && !stall[k] && (pkt[k] < maxp[k]);
            i_eop[k] = (beat[k] == len[k] - 1);
            i_dat[k*8 +: 8] = {2'(k), 3'(pkt[k]), 3'(beat[k])};
        end
    endtask

    task automatic reset_src();
        for (int k = 0; k < 4; k++) begin
            en[k] = 0; stall[k] = 0; len[k] = 1;
            beat[k] = 0; pkt[k] = 0; maxp[k] = 1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        hs = i_val & i_rdy;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            if (hs[k]) begin
                if (beat[k] == len[k] - 1) begin
                    beat[k] = 0;
                    pkt[k]++;
                end else begin
                    beat[k]++;
                end
            end
        end
        if (tog)
            o_rdy = ~o_rdy;
        drive();
    endtask

    task automatic clear_log();
        lg_port.delete(); lg_dat.delete();
        lg_eop.delete(); lg_cyc.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        reset_src();
        drive();
        tick();
        reset = 1'b0;
        clear_log();
    endtask

    task automatic wait_log(input int n, input int budget);
        int b = 0;
        while (lg_port.size() < n && b < budget) begin
            tick();
            b++;
        end
        chk("wait_beats", lg_port.size() >= n ? 1 : 0, 1);
    endtask

    int c0;

    initial begin
        reset = 1'b1;
        gap   = 8'd0;
        o_rdy = 1'b1;
        i_dat = '0;
        i_val = '0;
        i_eop = '0;
        reset_src();
        repeat (2) @(posedge clk);
        #1;
        chk("init_o_val", {31'b0, o_val}, 0);
        chk("init_i_rdy", {28'b0, i_rdy}, 0);
        chk("init_o_sel", {30'b0, o_sel}, 0);

        // Single port, then ptr must point at port 3
        do_reset();
        en[2] = 1; len[2] = 3; maxp[2] = 2;
        c0 = cyc + 1;
        drive();
        wait_log(6, 40);
        chk("s1_first_cyc", lg_cyc[0], c0 + 1);
        chk("s1_port", lg_port[0], 2);
        chk("s1_eop0", {31'b0, lg_eop[0]}, 0);
        chk("s1_eop1", {31'b0, lg_eop[1]}, 0);
        chk("s1_eop2", {31'b0, lg_eop[2]}, 1);
        chk("s1_dat0", {24'b0, lg_dat[0]}, 32'h80);
        chk("s1_dat2", {24'b0, lg_dat[2]}, 32'h82);
        chk("s1_bubble", lg_cyc[3] - lg_cyc[2], 2);
        en[0] = 1; en[3] = 1;
        drive();
        wait_log(8, 20);
        chk("s1_ptr3", lg_port[6], 3);
        chk("s1_then0", lg_port[7], 0);

        // Round robin, 2-beat packets on all ports
        do_reset();
        for (int k = 0; k < 4; k++) begin
            en[k] = 1; len[k] = 2; maxp[k] = 2;
        end
        drive();
        wait_log(16, 60);
        for (int i = 0; i < 8; i++) begin
            chk("rr_order", lg_port[2*i], i % 4);
            chk("rr_eop", {31'b0, lg_eop[2*i+1]}, 1);
            chk("rr_2beat", lg_cyc[2*i+1] - lg_cyc[2*i], 1);
            if (i < 7)
                chk("rr_bubble", lg_cyc[2*i+2] - lg_cyc[2*i+1], 2);
        end

        // Gap of 5, changed to 2 while in GAP
        do_reset();
        gap = 8'd5;
        en[0] = 1; len[0] = 2; maxp[0] = 3;
        drive();
        wait_log(2, 20);
        tick();
        tick();
        gap = 8'd2;
        wait_log(6, 60);
        chk("gap5", lg_cyc[2] - lg_cyc[1], 7);
        chk("gap2", lg_cyc[4] - lg_cyc[3], 4);
        gap = 8'd0;

        // Backpressure and mid-packet stall
        do_reset();
        en[1] = 1; len[1] = 4; maxp[1] = 1;
        drive();
        tick();
        en[0] = 1; en[3] = 1;
        tog = 1;
        drive();
        wait_log(2, 20);
        stall[1] = 1;
        drive();
        tick();
        tick();
        stall[1] = 0;
        drive();
        wait_log(6, 60);
        tog = 0;
        o_rdy = 1'b1;
        for (int b = 0; b < 4; b++) begin
            chk("bp_port", lg_port[b], 1);
            chk("bp_dat", {24'b0, lg_dat[b]}, 32'h40 + b);
        end
        chk("bp_eop2", {31'b0, lg_eop[2]}, 0);
        chk("bp_eop3", {31'b0, lg_eop[3]}, 1);
        chk("bp_next3", lg_port[4], 3);
        chk("bp_next0", lg_port[5], 0);

        // Wrap and skip from ptr=3
        do_reset();
        en[2] = 1;
        drive();
        wait_log(1, 10);
        en[2] = 0;
        en[1] = 1; en[3] = 1; maxp[1] = 2; maxp[3] = 2;
        drive();
        wait_log(4, 30);
        chk("ws_p2", lg_port[0], 2);
        chk("ws_3", lg_port[1], 3);
        chk("ws_1", lg_port[2], 1);
        chk("ws_3b", lg_port[3], 3);

        // Reset in the middle of a 4-beat packet on port 1
        do_reset();
        en[3] = 1;
        drive();
        wait_log(1, 10);
        en[3] = 0;
        drive();
        tick();
        tick();
        clear_log();
        en[1] = 1; len[1] = 4; maxp[1] = 1;
        drive();
        wait_log(1, 10);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_o_val", {31'b0, o_val}, 0);
        chk("mid_i_rdy", {28'b0, i_rdy}, 0);
        chk("mid_o_sel", {30'b0, o_sel}, 0);
        en[0] = 1;
        drive();
        tick();
        reset = 1'b0;
        clear_log();
        wait_log(4, 30);
        chk("mid_p0", lg_port[0], 0);
        chk("mid_p0_dat", {24'b0, lg_dat[0]}, 32'h00);
        chk("mid_p1", lg_port[1], 1);
        chk("mid_resume", {24'b0, lg_dat[1]}, 32'h41);
        chk("mid_last", {24'b0, lg_dat[3]}, 32'h43);
        chk("mid_eop", {31'b0, lg_eop[3]}, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
